pc_redirect_unit: RTL
=====================

// Module: pc_redirect_unit
// PURPOSE
//  Program-counter register and branch-resolution stage downstream of the branch target calculator.
//  Consumes branch_target/zero plus decode-side branch/jump strobes; picks next PC (jump > taken branch > PC+4).
//  On every redirect, flags younger in-flight instructions for squash via a FLUSH state machine.
//  Also keeps saturating branch statistics and a sticky misaligned-target error flag.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  FLUSH_CYCLES  2              unstalled cycles flush stays high after a redirect (>=1)
//  CNT_W         16             width of the statistics counters
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous, active-high reset
//  stall          in   1      1 = freeze PC, FSM and counters this cycle
//  branch_valid   in   1      conditional branch resolved this cycle
//  branch_type    in   1      0 = beq (taken if zero), 1 = bne (taken if !zero)
//  zero           in   1      equality flag from the branch target calculator
//  branch_target  in   32     target address from the branch target calculator
//  jump_valid     in   1      unconditional jump this cycle
//  jump_target    in   32     jump destination
//  pc             out  32     current fetch PC (registered)
//  pc_next        out  32     combinational next PC
//  flush          out  1      squash younger instructions (registered)
//  branch_cnt     out  CNT_W  branches resolved (saturating)
//  taken_cnt      out  CNT_W  branches + jumps that redirected (saturating)
//  misalign_err   out  1      sticky: a redirect target had addr[1:0] != 0
// BEHAVIOUR
//  - Reset (async, immediate): pc=RESET_PC, state=RUN, flush=0, flush counter=0, counters=0, misalign_err=0.
//  - accept = !stall && state==RUN; taken = branch_valid && (zero ^ branch_type).
//  - pc_next (comb): stall -> pc; accept&&jump_valid -> {jump_target[31:2],2'b00};
//    accept&&taken -> {branch_target[31:2],2'b00}; else pc+32'd4 (mod 2^32: FFFF_FFFC -> 0000_0000).
//  - pc <= pc_next every clock edge; latency 1 cycle from resolution strobe to redirected pc.
//  - Strobes while state==FLUSH belong to squashed instructions: ignored; pc keeps stepping by 4.
//  - FSM RUN: redirect (accept && (jump_valid||taken)) -> FLUSH, flush counter=FLUSH_CYCLES; else stay.
//  - FSM FLUSH: flush=1; each unstalled cycle decrements counter; counter reaching 0 -> RUN, flush=0.
//    stall in FLUSH holds counter and flush. flush high for exactly FLUSH_CYCLES unstalled cycles.
//  - branch_cnt += 1 on accept&&branch_valid; taken_cnt += 1 on accept&&(jump_valid||taken);
//    both saturate at all-ones, no wrap.
//  - jump_valid && branch_valid same cycle: jump wins; branch still counted in branch_cnt, taken_cnt +1 only.
//  - misalign_err set on an accepted redirect whose selected target[1:0]!=0; redirect still happens
//    to the word-aligned address; cleared only by rst.
//  - Reset asserted mid-FLUSH: flush drops immediately, state RUN, pc=RESET_PC.
// TESTING
//  1. rst pulse mid-run (pc=0x40, flush=1) -> pc=0x0, flush=0, counters 0 asynchronously, before next edge.
//  2. From 0x0, 3 free cycles -> pc 0x4,0x8,0xC; stall 2 cycles -> pc stays 0xC, pc_next=0xC.
//  3. pc=0x100, beq, zero=1, target 0x110 -> pc=0x110 next edge; flush=1 for 2 cycles; branch_cnt=1,
//     taken_cnt=1; branch_valid during flush ignored (pc 0x114, 0x118).
//  4. bne with zero=1 at pc=0x200 -> pc=0x204, flush stays 0, branch_cnt+1, taken_cnt unchanged.
//  5. pc=FFFF_FFFC, no strobes -> pc=0000_0000; then beq taken, target 0000_0004 -> pc=0000_0004.
//  6. jump_valid (0x300) and taken beq (0x400) same cycle -> pc=0x300, taken_cnt+1; later jump to
//     0x203 -> pc=0x200, misalign_err=1 and stays 1 until rst; force counters near all-ones -> saturate.

Source files
------------

// File: rtl/pc_redirect_if.sv
// Bundle between decode/branch-resolution logic and the PC redirect unit.
// The master drives resolution strobes; the slave returns PC, flush and statistics.
interface pc_redirect_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             branch_valid;
    logic             branch_type;
    logic             zero;
    logic [31:0]      branch_target;
    logic             jump_valid;
    logic [31:0]      jump_target;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic             flush;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic             misalign_err;

    modport master (
        output stall, branch_valid, branch_type, zero, branch_target, jump_valid, jump_target,
        input  pc, pc_next, flush, branch_cnt, taken_cnt, misalign_err
    );

    modport slave (
        input  stall, branch_valid, branch_type, zero, branch_target, jump_valid, jump_target,
        output pc, pc_next, flush, branch_cnt, taken_cnt, misalign_err
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// PC register and branch resolution: selects jump > taken branch > PC+4, raises a
// timed flush after each redirect, and keeps saturating branch statistics.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic          clk,
    input logic          rst,
    pc_redirect_if.slave bus
);
    localparam int unsigned FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state, state_nx;
    logic [FC_W-1:0]  fcnt, fcnt_nx;
    logic [31:0]      pc_q, pc_nx;
    logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;
    logic             misalign_q;
    logic             accept, taken, redirect;
    logic [31:0]      target_sel;

    always_comb begin
        accept     = !bus.stall && (state == RUN);
        taken      = bus.branch_valid && (bus.zero ^ bus.branch_type);
        redirect   = accept && (bus.jump_valid || taken);
        target_sel = bus.jump_valid ? bus.jump_target : bus.branch_target;

        if (bus.stall)
            pc_nx = pc_q;
        else if (redirect)
            pc_nx = {target_sel[31:2], 2'b00};
        else
            pc_nx = pc_q + 32'd4;
    end

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        case (state)
            RUN: begin
                if (redirect) begin
                    state_nx = FLUSH;
                    fcnt_nx  = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    fcnt_nx = fcnt - 1'b1;
                    if (fcnt_nx == '0)
                        state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
            pc_q  <= RESET_PC;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
            pc_q  <= pc_nx;
        end
    end

    // Counters stick at all-ones; misalign flag is cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            if (accept && bus.branch_valid && (branch_cnt_q != '1))
                branch_cnt_q <= branch_cnt_q + 1'b1;
            if (redirect && (taken_cnt_q != '1))
                taken_cnt_q <= taken_cnt_q + 1'b1;
            if (redirect && (target_sel[1:0] != 2'b00))
                misalign_q <= 1'b1;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_next      = pc_nx;
    assign bus.flush        = (state == FLUSH);
    assign bus.branch_cnt   = branch_cnt_q;
    assign bus.taken_cnt    = taken_cnt_q;
    assign bus.misalign_err = misalign_q;
endmodule
